// File: rtl/sys_mem_responder.sv
`timescale 1ns/1ps
// System-side memory responder for the cache S_strobe/S_rw bus: one single-word
// read or write per transaction, programmable wait states, out-of-range error flag.
module sys_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int WAITSTATES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  S_strobe,
   input  logic                  S_rw,
   input  logic [ADDR_WIDTH-1:0] S_addr,
   input  logic [DATA_WIDTH-1:0] S_wdata,
   output logic [DATA_WIDTH-1:0] S_rdata,
   output logic                  S_dataOE,
   output logic                  S_ready,
   output logic                  S_err,
   output logic                  S_busy
);

   localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [3:0]          CNT_INIT  = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;

   // DECODE is the cycle after the request is latched, where the range check
   // runs on the registered address before the wait phase starts.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DECODE  = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  rw_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  oe_q;
   logic                  ready_q;
   logic                  err_q;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  rng_err_s;
   logic                  enter_rsp_s;
   logic                  commit_s;
   logic [IDX_W-1:0]      idx_s;

   always_comb begin
      rng_err_s   = ({1'b0, addr_q} >= DEPTH_LIM);
      idx_s       = addr_q[IDX_W-1:0];
      enter_rsp_s = 1'b0;
      if (state_q == DECODE) begin
         enter_rsp_s = (WAITSTATES == 0);
      end else if (state_q == WAIT) begin
         enter_rsp_s = (cnt_q == 4'd0);
      end else begin
         enter_rsp_s = 1'b0;
      end
      commit_s = (state_q == RESPOND) && !rw_q && !rng_err_s;
   end

   // Storage array: not reset; a write lands on the edge leaving RESPOND.
   always_ff @(posedge clk) begin
      if (commit_s) begin
         mem_q[idx_s] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         oe_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         oe_q    <= 1'b0;
         rdata_q <= '0;
         case (state_q)
            IDLE, RESPOND: begin
               if (S_strobe) begin
                  rw_q    <= S_rw;
                  addr_q  <= S_addr;
                  wdata_q <= S_wdata;
                  state_q <= DECODE;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            DECODE: begin
               busy_q <= 1'b1;
               if (WAITSTATES > 0) begin
                  cnt_q   <= CNT_INIT;
                  state_q <= WAIT;
               end else begin
                  state_q <= RESPOND;
               end
            end
            WAIT: begin
               busy_q <= 1'b1;
               if (cnt_q == 4'd0) begin
                  state_q <= RESPOND;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
         if (enter_rsp_s) begin
            ready_q <= 1'b1;
            err_q   <= rng_err_s;
            oe_q    <= rw_q;
            rdata_q <= (rw_q && !rng_err_s) ? mem_q[idx_s] : '0;
         end
      end
   end

   assign S_rdata  = rdata_q;
   assign S_dataOE = oe_q;
   assign S_ready  = ready_q;
   assign S_err    = err_q;
   assign S_busy   = busy_q;

endmodule

// File: tb/tb_sys_mem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for sys_mem_responder: three instances (WAITSTATES 2, 0, 1)
// driven by directed transactions; a negedge monitor pops expected responses.
module tb_sys_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  strobe;
   logic [2:0]  rw;
   logic [15:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic [2:0]  oe;
   logic [2:0]  ready;
   logic [2:0]  err;
   logic [2:0]  busy;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      int          k;
      int          cyc;
      logic        err;
      logic        oe;
      logic [31:0] rd;
   } exp_t;

   exp_t        q[$];

   logic        b_rw   [4];
   logic [15:0] b_addr [4];
   logic [31:0] b_wd   [4];
   logic [31:0] b_exp  [4];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sys_mem_responder #(
         .DATA_WIDTH(32),
         .ADDR_WIDTH(16),
         .DEPTH(256),
         .WAITSTATES((g == 0) ? 2 : ((g == 1) ? 0 : 1))
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .S_strobe(strobe[g]),
         .S_rw(rw[g]),
         .S_addr(addr[g]),
         .S_wdata(wdata[g]),
         .S_rdata(rdata[g]),
         .S_dataOE(oe[g]),
         .S_ready(ready[g]),
         .S_err(err[g]),
         .S_busy(busy[g])
      );
   end

   function automatic int ws_of(input int k);
      case (k)
         0:       return 2;
         1:       return 0;
         default: return 1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int k, input int at, input logic r, input logic e, input logic [31:0] rd);
      exp_t x;
      x.k   = k;
      x.cyc = at;
      x.err = e;
      x.oe  = r;
      x.rd  = (r && !e) ? rd : 32'h0;
      q.push_back(x);
   endtask

   // Monitor: every ready pulse must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            if (ready[k]) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_ready: inst %0d cycle %0d", k, cyc);
               end else begin
                  e = q.pop_front();
                  check("rsp_inst", 32'(k), 32'(e.k));
                  check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                  check("rsp_err", {31'h0, err[k]}, {31'h0, e.err});
                  check("rsp_oe", {31'h0, oe[k]}, {31'h0, e.oe});
                  check("rsp_rdata", rdata[k], e.rd);
               end
            end else begin
               check("idle_err_oe", {30'h0, err[k], oe[k]}, 32'h0);
            end
            if (!oe[k]) begin
               check("rdata_zero_when_no_oe", rdata[k], 32'h0);
            end
         end
      end
   end

   task automatic issue(input int k, input logic r, input logic [15:0] a, input logic [31:0] wd,
                        input logic e, input logic [31:0] rd, input bit expect_rsp);
      @(negedge clk);
      strobe[k] = 1'b1;
      rw[k]     = r;
      addr[k]   = a;
      wdata[k]  = wd;
      if (expect_rsp) push_exp(k, cyc + 2 + ws_of(k), r, e, rd);
      @(posedge clk);
      #1;
      strobe[k] = 1'b0;
      rw[k]     = ~r;
      addr[k]   = 16'hFFFF;
      wdata[k]  = 32'hBAD0BAD0;
      check("busy_after_strobe", {31'h0, busy[k]}, 32'h1);
   endtask

   task automatic wait_ready(input int k);
      int n;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ready[k]) break;
      end
      if (n == 50) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: inst %0d got no ready want ready within 50 cycles", k);
      end
   endtask

   task automatic txn(input int k, input logic r, input logic [15:0] a, input logic [31:0] wd,
                      input logic e, input logic [31:0] rd);
      issue(k, r, a, wd, e, rd, 1'b1);
      wait_ready(k);
   endtask

   // Strobe held high for n requests; inputs change right after each accepting edge.
   task automatic burst(input int k, input int n);
      int c0;
      int p;
      p = ws_of(k) + 2;
      @(negedge clk);
      c0 = cyc;
      strobe[k] = 1'b1;
      for (int i = 0; i < n; i++) begin
         rw[k]    = b_rw[i];
         addr[k]  = b_addr[i];
         wdata[k] = b_wd[i];
         push_exp(k, c0 + 1 + i * p + ws_of(k) + 1, b_rw[i], 1'b0, b_exp[i]);
         repeat ((i == 0) ? 1 : p) @(posedge clk);
         #1;
      end
      strobe[k] = 1'b0;
      repeat (p + 3) @(negedge clk);
   endtask

   task automatic check_quiet(input string name, input int k);
      check(name, {28'h0, ready[k], err[k], oe[k], busy[k]}, 32'h0);
      check({name, "_rdata"}, rdata[k], 32'h0);
   endtask

   initial begin
      rst    = 1'b0;
      strobe = 3'b000;
      rw     = 3'b000;
      for (int k = 0; k < 3; k++) begin
         addr[k]  = 16'h0;
         wdata[k] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) check_quiet("reset_state", k);
      rst = 1'b1;

      // WAITSTATES = 2: write/read, out of range, strobe while busy
      txn(0, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0);
      txn(0, 1'b1, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF);
      txn(0, 1'b0, 16'h0000, 32'hA5A5A5A5, 1'b0, 32'h0);
      txn(0, 1'b0, 16'h0100, 32'h12345678, 1'b1, 32'h0);
      txn(0, 1'b1, 16'h0000, 32'h0,        1'b0, 32'hA5A5A5A5);
      txn(0, 1'b1, 16'h0100, 32'h0,        1'b1, 32'h0);
      txn(0, 1'b1, 16'hFFFF, 32'h0,        1'b1, 32'h0);
      txn(0, 1'b1, 16'h00FF, 32'h0,        1'b0, 32'h0);
      txn(0, 1'b0, 16'h0003, 32'h00000033, 1'b0, 32'h0);
      txn(0, 1'b0, 16'h0007, 32'h00000077, 1'b0, 32'h0);
      issue(0, 1'b1, 16'h0003, 32'h0, 1'b0, 32'h00000033, 1'b1);
      issue(0, 1'b0, 16'h0007, 32'h00000001, 1'b0, 32'h0, 1'b0);
      wait_ready(0);
      repeat (4) @(negedge clk);
      txn(0, 1'b1, 16'h0007, 32'h0, 1'b0, 32'h00000077);

      // Reset while the write to addr 9 sits in WAIT
      txn(0, 1'b0, 16'h0009, 32'h00000009, 1'b0, 32'h0);
      issue(0, 1'b0, 16'h0009, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_quiet("reset_mid_wait", 0);
      repeat (2) @(negedge clk);
      check_quiet("reset_held", 0);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      txn(0, 1'b1, 16'h0009, 32'h0, 1'b0, 32'h00000009);

      // WAITSTATES = 0
      txn(1, 1'b0, 16'h0005, 32'h00000055, 1'b0, 32'h0);
      txn(1, 1'b1, 16'h0005, 32'h0,        1'b0, 32'h00000055);
      b_rw[0] = 1'b0; b_addr[0] = 16'h0006; b_wd[0] = 32'h00000066; b_exp[0] = 32'h0;
      b_rw[1] = 1'b1; b_addr[1] = 16'h0006; b_wd[1] = 32'h0;        b_exp[1] = 32'h00000066;
      burst(1, 2);

      // WAITSTATES = 1: four back-to-back reads with strobe held
      txn(2, 1'b0, 16'h0020, 32'h11111111, 1'b0, 32'h0);
      txn(2, 1'b0, 16'h0021, 32'h22222222, 1'b0, 32'h0);
      txn(2, 1'b0, 16'h0022, 32'h33333333, 1'b0, 32'h0);
      txn(2, 1'b0, 16'h00FE, 32'h44444444, 1'b0, 32'h0);
      b_rw[0] = 1'b1; b_addr[0] = 16'h0021; b_wd[0] = 32'h0; b_exp[0] = 32'h22222222;
      b_rw[1] = 1'b1; b_addr[1] = 16'h0020; b_wd[1] = 32'h0; b_exp[1] = 32'h11111111;
      b_rw[2] = 1'b1; b_addr[2] = 16'h00FE; b_wd[2] = 32'h0; b_exp[2] = 32'h44444444;
      b_rw[3] = 1'b1; b_addr[3] = 16'h0022; b_wd[3] = 32'h0; b_exp[3] = 32'h33333333;
      burst(2, 4);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
